// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1-style serial receiver, mid-bit sampled, one-cycle DV pulse
// Revision: 1.0
// ============================================================================
module uart_rx #(
  parameter int NB           = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_Rx_Serial,
  output logic          o_Rx_DV,
  output logic [NB-1:0] o_Rx_Byte,
  output logic          o_Rx_Active,
  output logic          o_Rx_Frame_Err
);

  localparam int c_CW = $clog2(CLKS_PER_BIT);
  localparam int c_IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [c_CW-1:0] c_HALF     = c_CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NB - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_START   = 3'd1;
  localparam logic [2:0] c_DATA    = 3'd2;
  localparam logic [2:0] c_STOP    = 3'd3;
  localparam logic [2:0] c_CLEANUP = 3'd4;

  logic            r_Rx_Meta;
  logic            r_Rx;
  logic [2:0]      r_State;
  logic [c_CW-1:0] r_Clk_Count;
  logic [c_IW-1:0] r_Bit_Index;
  logic [NB-1:0]   r_Shift;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_State        <= c_IDLE;
      r_Clk_Count    <= '0;
      r_Bit_Index    <= '0;
      r_Shift        <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= '0;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (r_State)
        c_IDLE: begin
          r_Clk_Count <= '0;
          r_Bit_Index <= '0;
          o_Rx_Active <= 1'b0;
          if (r_Rx == 1'b0) begin
            r_State     <= c_START;
            o_Rx_Active <= 1'b1;
          end
        end

        c_START: begin
          if (r_Clk_Count == c_HALF) begin
            r_Clk_Count <= '0;
            if (r_Rx == 1'b0) begin
              r_State <= c_DATA;
            end else begin
              r_State     <= c_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end

        c_DATA: begin
          if (r_Clk_Count == c_LAST) begin
            r_Clk_Count          <= '0;
            r_Shift[r_Bit_Index] <= r_Rx;
            if (r_Bit_Index == c_IDX_LAST) begin
              r_Bit_Index <= '0;
              r_State     <= c_STOP;
            end else begin
              r_Bit_Index <= r_Bit_Index + 1'b1;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end

        c_STOP: begin
          if (r_Clk_Count == c_LAST) begin
            r_Clk_Count <= '0;
            r_State     <= c_CLEANUP;
            o_Rx_Active <= 1'b0;
            if (r_Rx == 1'b1) begin
              o_Rx_DV   <= 1'b1;
              o_Rx_Byte <= r_Shift;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end

        c_CLEANUP: begin
          r_State <= c_IDLE;
        end

        default: begin
          r_State     <= c_IDLE;
          r_Clk_Count <= '0;
          r_Bit_Index <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : table-driven check of uart_rx at 8 clocks per bit
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

  localparam int c_NB  = 8;
  localparam int c_CPB = 8;
  localparam int c_LAT = 2 + (c_CPB - 1) / 2 + 1 + (c_NB + 1) * c_CPB;

  localparam int c_PRE_NONE   = 0;
  localparam int c_PRE_GLITCH = 1;
  localparam int c_PRE_RESET  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rx;
  logic            dv;
  logic [c_NB-1:0] rx_byte;
  logic            active;
  logic            ferr;

  uart_rx #(.NB(c_NB), .CLKS_PER_BIT(c_CPB)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Serial   (rx),
    .o_Rx_DV       (dv),
    .o_Rx_Byte     (rx_byte),
    .o_Rx_Active   (active),
    .o_Rx_Frame_Err(ferr)
  );

  always #5 clk = ~clk;

  int        cyc      = 0;
  int        dv_cnt   = 0;
  int        err_cnt  = 0;
  int        both_cnt = 0;
  int        dv_cyc   = 0;
  logic [7:0] dv_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (dv) begin
      dv_cnt  <= dv_cnt + 1;
      dv_byte <= rx_byte;
      dv_cyc  <= cyc;
    end
    if (ferr) err_cnt <= err_cnt + 1;
    if (dv && ferr) both_cnt <= both_cnt + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pre;
    logic       gap;
    int         exp_dv;
    int         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[7];
  int   start_cyc;
  int   act_lows;

  task automatic send_frame(input logic [7:0] d, input logic s);
    logic [9:0] bits;
    bits      = {s, d, 1'b0};
    start_cyc = cyc + 1;
    act_lows  = 0;
    for (int j = 0; j < 10 * c_CPB; j++) begin
      rx = bits[j / c_CPB];
      @(negedge clk);
      if (j >= 3 && j <= c_LAT - 2 && active !== 1'b1) act_lows++;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_glitch();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_active_hi", {31'd0, active}, 32'd1);
    repeat (5) @(negedge clk);
    chk("glitch_active_lo", {31'd0, active}, 32'd0);
    idle(10);
  endtask

  // Start 0x77, abort with reset partway through data bit 4.
  task automatic do_reset_abort();
    logic [8:0] bits;
    bits = {8'h77, 1'b0};
    for (int j = 0; j < 5 * c_CPB + 4; j++) begin
      rx = bits[j / c_CPB];
      @(negedge clk);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("abort_byte_cleared", {24'd0, rx_byte}, 32'h00);
    chk("abort_active", {31'd0, active}, 32'd0);
  endtask

  initial begin
    int dv0, err0, lat;

    vecs[0] = '{8'hA5, 1'b1, c_PRE_NONE,   1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, c_PRE_NONE,   1'b0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, c_PRE_NONE,   1'b0, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, c_PRE_NONE,   1'b1, 1, 0, 8'h3C};
    vecs[4] = '{8'h5A, 1'b1, c_PRE_GLITCH, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'h81, 1'b0, c_PRE_NONE,   1'b1, 0, 1, 8'h5A};
    vecs[6] = '{8'h12, 1'b1, c_PRE_RESET,  1'b1, 1, 0, 8'h12};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dv",     {31'd0, dv},     32'd0);
    chk("rst_byte",   {24'd0, rx_byte}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_ferr",   {31'd0, ferr},   32'd0);
    rst_n = 1'b1;
    idle(100);
    chk("idle_active", {31'd0, active}, 32'd0);
    chk("idle_byte",   {24'd0, rx_byte}, 32'd0);
    chk("idle_dv_cnt", dv_cnt, 0);
    chk("idle_err_cnt", err_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      dv0  = dv_cnt;
      err0 = err_cnt;
      if (vecs[i].pre == c_PRE_GLITCH) do_glitch();
      else if (vecs[i].pre == c_PRE_RESET) do_reset_abort();
      send_frame(vecs[i].data, vecs[i].stop);
      chk($sformatf("v%0d_dv_count", i),  dv_cnt - dv0,  vecs[i].exp_dv);
      chk($sformatf("v%0d_err_count", i), err_cnt - err0, vecs[i].exp_err);
      chk($sformatf("v%0d_byte", i), {24'd0, rx_byte}, {24'd0, vecs[i].exp_byte});
      chk($sformatf("v%0d_active_lows", i), act_lows, 0);
      if (vecs[i].exp_dv == 1) begin
        chk($sformatf("v%0d_dv_byte", i), {24'd0, dv_byte}, {24'd0, vecs[i].exp_byte});
        lat = dv_cyc - start_cyc;
        n_total++;
        if (lat >= c_LAT - 1 && lat <= c_LAT + 1) n_pass++;
        else $display("FAIL v%0d_latency: got %0d expected %0d +/-1", i, lat, c_LAT);
      end
      if (vecs[i].gap) idle(30);
    end

    chk("dv_err_overlap", both_cnt, 0);
    chk("final_active", {31'd0, active}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
